// File: rtl/seg_scan_monitor.sv
// Snoops a 4-digit multiplexed seven-segment display and rebuilds the hex word it shows.
// Latency: 2-cycle input sync + SETTLE_CYCLES stable + 1 capture; frame_valid 1 cycle after the 4th capture.
// Backpressure: none; passive observer, outputs hold their last frame until the next one completes.
module seg_scan_monitor #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TW             = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic        frame_valid,
    output logic        overlap_err,
    output logic        stale
);

    // Settle counter must hold values up to SETTLE_CYCLES-1 (SETTLE_CYCLES >= 2 assumed).
    localparam int            CW          = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    // Segment pattern {a..g}, active-low, to {blank, invalid, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'h01:   r = {2'b00, 4'h0};
            7'h4F:   r = {2'b00, 4'h1};
            7'h12:   r = {2'b00, 4'h2};
            7'h06:   r = {2'b00, 4'h3};
            7'h4C:   r = {2'b00, 4'h4};
            7'h24:   r = {2'b00, 4'h5};
            7'h20:   r = {2'b00, 4'h6};
            7'h0F:   r = {2'b00, 4'h7};
            7'h00:   r = {2'b00, 4'h8};
            7'h04:   r = {2'b00, 4'h9};
            7'h08:   r = {2'b00, 4'hA};
            7'h60:   r = {2'b00, 4'hB};
            7'h31:   r = {2'b00, 4'hC};
            7'h42:   r = {2'b00, 4'hD};
            7'h30:   r = {2'b00, 4'hE};
            7'h38:   r = {2'b00, 4'hF};
            7'h7F:   r = {2'b10, 4'h0};
            default: r = {2'b01, 4'h0};
        endcase
        return r;
    endfunction

    logic [10:0]   sync1;
    logic [10:0]   sync2;
    logic [3:0]    an_low;
    logic [6:0]    seg;
    logic [2:0]    n_low;
    logic          single;
    logic          multi;
    logic [1:0]    cur_idx;

    state_t        state;
    logic [1:0]    idx;
    logic [6:0]    pat;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    seen;
    logic [15:0]   sh_val;
    logic [3:0]    sh_blank;
    logic [3:0]    sh_inv;

    logic [5:0]    dec;
    logic [15:0]   cap_val;
    logic [3:0]    cap_blank;
    logic [3:0]    cap_inv;
    logic [3:0]    cap_seen;
    logic          eval;
    logic          frame_done;

    logic          multi_d;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_inc;

    // Two-flop synchronizer on every display line; resets to the all-off level so nothing looks driven.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {an3, an2, an1, an0, a, b, c, d, e, f, g};
            sync2 <= sync1;
        end
    end

    assign an_low = ~sync2[10:7];
    assign seg    = sync2[6:0];

    // Classify the anode lines: how many are driven and which one when exactly one is.
    always_comb begin
        n_low   = 3'(an_low[0]) + 3'(an_low[1]) + 3'(an_low[2]) + 3'(an_low[3]);
        single  = (n_low == 3'd1);
        multi   = (n_low > 3'd1);
        cur_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (an_low[i]) cur_idx = 2'(i);
        end
    end

    // Shadow slot merge for the digit being captured, plus the re-evaluate decision per state.
    always_comb begin
        dec                       = decode(pat);
        cnt_inc                   = cnt + CW'(1);
        cap_val                   = sh_val;
        cap_val[{idx, 2'b00} +: 4] = dec[3:0];
        cap_blank                 = sh_blank;
        cap_blank[idx]            = dec[5];
        cap_inv                   = sh_inv;
        cap_inv[idx]              = dec[4];
        cap_seen                  = seen;
        cap_seen[idx]             = 1'b1;
        frame_done                = (state == CAPTURE) && !multi && (cap_seen == 4'hF);
        eval                      = 1'b0;
        case (state)
            IDLE:    eval = 1'b1;
            SETTLE:  eval = !(single && (cur_idx == idx) && (seg == pat));
            HOLD:    eval = !an_low[idx];
            default: eval = 1'b0;
        endcase
    end

    // Scan-tracking FSM: settle on one digit, capture it into the shadow, publish when all four are seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            pat         <= '1;
            cnt         <= '0;
            seen        <= 4'h0;
            sh_val      <= 16'h0;
            sh_blank    <= 4'h0;
            sh_inv      <= 4'h0;
            value       <= 16'h0;
            blank       <= 4'h0;
            invalid     <= 4'h0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (multi) begin
                // Ghosted anodes: drop whatever was in progress, nothing is sampled.
                state <= IDLE;
            end else if (eval) begin
                if (single) begin
                    idx   <= cur_idx;
                    pat   <= seg;
                    cnt   <= '0;
                    state <= SETTLE;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    SETTLE: begin
                        cnt <= cnt_inc;
                        if (cnt_inc == SETTLE_LAST) state <= CAPTURE;
                    end
                    CAPTURE: begin
                        sh_val   <= cap_val;
                        sh_blank <= cap_blank;
                        sh_inv   <= cap_inv;
                        state    <= HOLD;
                        if (frame_done) begin
                            value       <= cap_val;
                            blank       <= cap_blank;
                            invalid     <= cap_inv;
                            frame_valid <= 1'b1;
                            seen        <= 4'h0;
                        end else begin
                            seen <= cap_seen;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // One overlap_err pulse per entry into the multiple-anodes-low condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            multi_d     <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            multi_d     <= multi;
            overlap_err <= multi && !multi_d;
        end
    end

    assign tcnt_inc = tcnt + TW'(1);

    // Frame watchdog: saturating count since the last frame; stale mirrors the saturated state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (frame_done) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (tcnt != TIMEOUT_MAX) begin
            tcnt  <= tcnt_inc;
            stale <= (tcnt_inc == TIMEOUT_MAX);
        end else begin
            stale <= 1'b1;
        end
    end

endmodule
